// File: rtl/shift_universal_register.sv
// Universal shift register: hold, shift, rotate, arithmetic shift,
// load and clear, with a per-frame shift counter and done pulse.
module shift_universal_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2:0]               mode,
  input  logic                     si,
  input  logic [WIDTH-1:0]         pi,
  output logic [WIDTH-1:0]         po,
  output logic                     so_msb,
  output logic                     so_lsb,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     frame_done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHL   = 3'b001,
    M_SHR   = 3'b010,
    M_ROL   = 3'b011,
    M_ROR   = 3'b100,
    M_ASR   = 3'b101,
    M_LOAD  = 3'b110,
    M_CLEAR = 3'b111
  } mode_e;

  mode_e            op;
  logic [WIDTH-1:0] po_nxt;
  logic             is_shift;
  logic             is_restart;
  logic             last;

  assign op     = mode_e'(mode);
  assign so_msb = po[WIDTH-1];
  assign so_lsb = po[0];
  assign last   = (bit_cnt == CW'(WIDTH - 1));

  always_comb begin
    po_nxt     = po;
    is_shift   = 1'b0;
    is_restart = 1'b0;
    unique case (op)
      M_HOLD: po_nxt = po;
      M_SHL: begin
        po_nxt   = {po[WIDTH-2:0], si};
        is_shift = 1'b1;
      end
      M_SHR: begin
        po_nxt   = {si, po[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      M_ROL: begin
        po_nxt   = {po[WIDTH-2:0], po[WIDTH-1]};
        is_shift = 1'b1;
      end
      M_ROR: begin
        po_nxt   = {po[0], po[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      M_ASR: begin
        po_nxt   = {po[WIDTH-1], po[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      M_LOAD: begin
        po_nxt     = pi;
        is_restart = 1'b1;
      end
      M_CLEAR: begin
        po_nxt     = RESET_VALUE;
        is_restart = 1'b1;
      end
    endcase
  end

  // frame_done defaults low each edge so it only ever pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      po         <= RESET_VALUE;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (en) begin
        po <= po_nxt;
        if (is_shift) begin
          if (last) begin
            bit_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else if (is_restart) begin
          bit_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_universal_register.sv
// Bench for shift_universal_register: WIDTH=8 and WIDTH=5 instances
// checked against an arithmetic model, plus directed literal checks.
module tb_shift_universal_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic       si;
  logic [7:0] pi;

  logic [7:0] po8;
  logic       msb8, lsb8, fd8;
  logic [2:0] cnt8;
  logic [4:0] po5;
  logic       msb5, lsb5, fd5;
  logic [2:0] cnt5;

  int vectors = 0;
  int errors  = 0;
  bit chk_on  = 1'b0;

  int m_po[2];
  int m_cnt[2];
  int m_fd[2];
  int wd[2] = '{8, 5};

  always #5 clk = ~clk;

  shift_universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) u8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .si(si), .pi(pi),
    .po(po8), .so_msb(msb8), .so_lsb(lsb8),
    .bit_cnt(cnt8), .frame_done(fd8)
  );

  shift_universal_register #(.WIDTH(5), .RESET_VALUE(5'h00)) u5 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .si(si), .pi(pi[4:0]),
    .po(po5), .so_msb(msb5), .so_lsb(lsb5),
    .bit_cnt(cnt5), .frame_done(fd5)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on an integer of width w
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int w, mask, p, top;
      w    = wd[k];
      mask = (1 << w) - 1;
      p    = m_po[k];
      top  = (p >> (w - 1)) & 1;
      m_fd[k] = 0;
      if (rst) begin
        m_po[k]  = 0;
        m_cnt[k] = 0;
      end else if (en) begin
        case (mode)
          3'd1: m_po[k] = ((p << 1) | int'(si)) & mask;
          3'd2: m_po[k] = (p >> 1) | (int'(si) << (w - 1));
          3'd3: m_po[k] = ((p << 1) | top) & mask;
          3'd4: m_po[k] = (p >> 1) | ((p & 1) << (w - 1));
          3'd5: m_po[k] = (p >> 1) | (top << (w - 1));
          3'd6: m_po[k] = int'(pi) & mask;
          3'd7: m_po[k] = 0;
          default: m_po[k] = p;
        endcase
        if (mode >= 3'd1 && mode <= 3'd5) begin
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == w) begin
            m_cnt[k] = 0;
            m_fd[k]  = 1;
          end
        end else if (mode >= 3'd6) begin
          m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input int md,
                      input bit s, input int p);
    rst  = r;
    en   = e;
    mode = 3'(md);
    si   = s;
    pi   = 8'(p);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("po8", int'(po8), m_po[0]);
      chk("cnt8", int'(cnt8), m_cnt[0]);
      chk("fd8", int'(fd8), m_fd[0]);
      chk("msb8", int'(msb8), (m_po[0] >> 7) & 1);
      chk("lsb8", int'(lsb8), m_po[0] & 1);
      chk("po5", int'(po5), m_po[1]);
      chk("cnt5", int'(cnt5), m_cnt[1]);
      chk("fd5", int'(fd5), m_fd[1]);
      chk("msb5", int'(msb5), (m_po[1] >> 4) & 1);
      chk("lsb5", int'(lsb5), m_po[1] & 1);
    end
  end

  initial begin
    int sh_bits[8] = '{1, 0, 1, 1, 0, 1, 0, 1};
    int hold_po, hold_cnt;
    longint pulses8, pulses5;

    rst = 1'b1; en = 1'b0; mode = '0; si = 1'b0; pi = '0;
    step(1, 0, 0, 0, 0);
    chk_on = 1'b1;
    chk("reset_po", int'(po8), 0);
    chk("reset_cnt", int'(cnt8), 0);
    chk("reset_fd", int'(fd8), 0);

    // serial-in frame
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, sh_bits[i][0], 0);
      if (i < 7) chk("t1_nofd", int'(fd8), 0);
    end
    chk("t1_po", int'(po8), 'hB5);
    chk("t1_fd", int'(fd8), 1);
    chk("t1_cnt", int'(cnt8), 0);

    step(0, 1, 6, 0, 'hA5);
    step(0, 1, 3, 0, 0);
    chk("rol", int'(po8), 'h4B);
    step(0, 1, 6, 0, 'hA5);
    step(0, 1, 4, 0, 0);
    chk("ror", int'(po8), 'hD2);
    step(0, 1, 6, 0, 'h00);
    step(0, 1, 2, 1, 0);
    chk("shr1", int'(po8), 'h80);
    step(0, 1, 2, 1, 0);
    chk("shr2", int'(po8), 'hC0);

    step(0, 1, 6, 0, 'h90);
    step(0, 1, 5, 0, 0);
    chk("asr1", int'(po8), 'hC8);
    step(0, 1, 5, 0, 0);
    chk("asr2", int'(po8), 'hE4);
    step(0, 1, 6, 0, 'h10);
    step(0, 1, 5, 0, 0);
    chk("asr_pos", int'(po8), 'h08);

    // reset in the middle of a frame
    step(0, 1, 7, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    chk("midrst_po", int'(po8), 0);
    chk("midrst_cnt", int'(cnt8), 0);
    chk("midrst_fd", int'(fd8), 0);
    for (int i = 0; i < 7; i++) step(0, 1, 1, 1, 0);
    chk("midrst_7", int'(fd8), 0);
    step(0, 1, 1, 1, 0);
    chk("midrst_8", int'(fd8), 1);

    // enable low overrides mode
    step(0, 1, 6, 0, 'h3C);
    step(0, 1, 1, 1, 0);
    hold_po  = 'h79;
    hold_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, i[0], 0);
      chk("en0_po", int'(po8), hold_po);
      chk("en0_cnt", int'(cnt8), hold_cnt);
      chk("en0_fd", int'(fd8), 0);
    end
    step(0, 1, 7, 0, 0);
    chk("clr_po", int'(po8), 0);
    chk("clr_cnt", int'(cnt8), 0);

    // continuous shifting, both widths
    step(1, 0, 0, 0, 0);
    pulses8 = 0;
    pulses5 = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 1, 1, 0);
      if (fd8) pulses8 |= (64'd1 << i);
      if (fd5) pulses5 |= (64'd1 << i);
    end
    chk("pulses8", int'(pulses8), (1 << 8) | (1 << 16));
    chk("pulses5", int'(pulses5),
        (1 << 5) | (1 << 10) | (1 << 15) | (1 << 20));
    chk("cnt8_end", int'(cnt8), 4);
    chk("cnt5_end", int'(cnt5), 0);

    // load right after a frame completes
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    chk("fd_before_load", int'(fd8), 1);
    step(0, 1, 6, 0, 'h5A);
    chk("load_after_fd", int'(fd8), 0);
    chk("load_cnt", int'(cnt8), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 7),
           1'($urandom),
           $urandom_range(0, 255));
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
